// File: rtl/error_injector_multimode.sv
// -----------------------------------------------------------------------------
// error_injector_multimode
//
// Multi-mode fault injector placed between an AN-code encoder and its decoder.
// Words pass through a one-cycle register stage. Once armed, a 32-bit LFSR
// compared against a programmable threshold decides whether a valid word
// triggers a fault event. The event corrupts one bit, chosen either by a fixed
// index or by the LFSR, as stuck-at-0, stuck-at-1 or bit-flip. The event lasts
// one word, N words or until cleared.
//
// Ports
//   i_clk, i_rst_n      clock (rising edge), asynchronous active-low reset
//   i_clk_en            global advance; low freezes every register
//   i_cfg_load          latch threshold/mode/duration/index config (IDLE only)
//   i_threshold         trigger when lfsr < threshold (unsigned)
//   i_mode              00 off, 01 stuck-at-0, 10 stuck-at-1, 11 bit-flip
//   i_duration          words per event, 0 = permanent until i_clear
//   i_random_idx_en     1: LFSR-derived bit index, 0: i_fixed_idx
//   i_fixed_idx         fixed target bit
//   i_arm / i_clear     IDLE -> ARMED / abort and return to IDLE
//   i_valid, i_codeword input word
//   o_valid, o_codeword registered, possibly corrupted word
//   o_fault_hit         the registered word was corrupted
//   o_fault_idx         bit index of the current or last fault
//   o_inject_count      saturating count of trigger events since reset
//   o_busy              state != IDLE
// -----------------------------------------------------------------------------
module error_injector_multimode #(
   parameter int unsigned CODEWORD_LENGTH = 29,
   parameter int unsigned IDX_WIDTH       = 5,
   parameter logic [31:0] LFSR_SEED       = 32'hACE10001
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_clk_en,
   input  logic                       i_cfg_load,
   input  logic [31:0]                i_threshold,
   input  logic [1:0]                 i_mode,
   input  logic [15:0]                i_duration,
   input  logic                       i_random_idx_en,
   input  logic [IDX_WIDTH-1:0]       i_fixed_idx,
   input  logic                       i_arm,
   input  logic                       i_clear,
   input  logic                       i_valid,
   input  logic [CODEWORD_LENGTH-1:0] i_codeword,
   output logic                       o_valid,
   output logic [CODEWORD_LENGTH-1:0] o_codeword,
   output logic                       o_fault_hit,
   output logic [IDX_WIDTH-1:0]       o_fault_idx,
   output logic [15:0]                o_inject_count,
   output logic                       o_busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_ACTIVE} state_e;

   localparam logic [1:0] MODE_OFF  = 2'b00;
   localparam logic [1:0] MODE_SA0  = 2'b01;
   localparam logic [1:0] MODE_SA1  = 2'b10;
   localparam logic [1:0] MODE_FLIP = 2'b11;

   localparam logic [CODEWORD_LENGTH-1:0] ONE_LSB = CODEWORD_LENGTH'(1);

   function automatic logic [CODEWORD_LENGTH-1:0] corrupt(
      input logic [CODEWORD_LENGTH-1:0] data,
      input logic [CODEWORD_LENGTH-1:0] mask,
      input logic [1:0]                 mode
   );
      case (mode)
         MODE_SA0:  corrupt = data & ~mask;
         MODE_SA1:  corrupt = data | mask;
         MODE_FLIP: corrupt = data ^ mask;
         default:   corrupt = data;
      endcase
   endfunction

   state_e                       state_q, state_d;
   logic [31:0]                  lfsr_q, lfsr_d;
   logic [31:0]                  thr_q, thr_d;
   logic [1:0]                   mode_q, mode_d;
   logic [15:0]                  dur_q, dur_d;
   logic                         rnd_en_q, rnd_en_d;
   logic [IDX_WIDTH-1:0]         fixed_idx_q, fixed_idx_d;
   logic [CODEWORD_LENGTH-1:0]   mask_q, mask_d;
   logic [15:0]                  remaining_q, remaining_d;
   logic [IDX_WIDTH-1:0]         fault_idx_q, fault_idx_d;
   logic [15:0]                  inject_count_q, inject_count_d;
   logic                         valid_q, valid_d;
   logic [CODEWORD_LENGTH-1:0]   codeword_q, codeword_d;
   logic                         fault_hit_q, fault_hit_d;
   logic                         busy_q, busy_d;

   logic [IDX_WIDTH-1:0]         cur_idx;
   logic [CODEWORD_LENGTH-1:0]   new_mask;
   logic [CODEWORD_LENGTH-1:0]   apply_mask;
   logic                         trigger;

   // An out-of-range fixed index shifts the single bit past the MSB, leaving an
   // all-zero mask while the event still counts as a trigger.
   assign cur_idx  = i_random_idx_en_sel();
   assign new_mask = ONE_LSB << cur_idx;
   assign trigger  = i_valid && (mode_q != MODE_OFF) && (lfsr_q < thr_q);

   function automatic logic [IDX_WIDTH-1:0] i_random_idx_en_sel();
      if (rnd_en_q) i_random_idx_en_sel = IDX_WIDTH'({16'd0, lfsr_q[15:0]} % CODEWORD_LENGTH);
      else          i_random_idx_en_sel = fixed_idx_q;
   endfunction

   // NOTE: every always_comb output gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_d        = state_q;
      thr_d          = thr_q;
      mode_d         = mode_q;
      dur_d          = dur_q;
      rnd_en_d       = rnd_en_q;
      fixed_idx_d    = fixed_idx_q;
      mask_d         = mask_q;
      remaining_d    = remaining_q;
      fault_idx_d    = fault_idx_q;
      inject_count_d = inject_count_q;
      apply_mask     = '0;
      fault_hit_d    = 1'b0;

      // Fibonacci taps for x^32 + x^22 + x^2 + x + 1; runs in every state.
      lfsr_d = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};

      if (i_clear) begin
         state_d     = ST_IDLE;
         mask_d      = '0;
         remaining_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_cfg_load) begin
                  thr_d       = i_threshold;
                  mode_d      = i_mode;
                  dur_d       = i_duration;
                  rnd_en_d    = i_random_idx_en;
                  fixed_idx_d = i_fixed_idx;
               end
               if (i_arm) state_d = ST_ARMED;
            end
            ST_ARMED: begin
               if (trigger) begin
                  mask_d      = new_mask;
                  fault_idx_d = cur_idx;
                  apply_mask  = new_mask;
                  fault_hit_d = 1'b1;
                  if (inject_count_q != 16'hFFFF) inject_count_d = inject_count_q + 16'd1;
                  if (dur_q == 16'd0) begin
                     state_d = ST_ACTIVE;
                  end else if (dur_q != 16'd1) begin
                     state_d     = ST_ACTIVE;
                     remaining_d = dur_q - 16'd1;
                  end
               end
            end
            ST_ACTIVE: begin
               if (i_valid) begin
                  apply_mask  = mask_q;
                  fault_hit_d = 1'b1;
                  // Permanent events (dur 0) never count down.
                  if (dur_q != 16'd0) begin
                     remaining_d = remaining_q - 16'd1;
                     if (remaining_q == 16'd1) state_d = ST_ARMED;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      valid_d    = i_valid;
      codeword_d = corrupt(i_codeword, apply_mask, mode_q);
      busy_d     = (state_d != ST_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q        <= ST_IDLE;
         lfsr_q         <= LFSR_SEED;
         thr_q          <= '0;
         mode_q         <= MODE_OFF;
         dur_q          <= '0;
         rnd_en_q       <= 1'b0;
         fixed_idx_q    <= '0;
         mask_q         <= '0;
         remaining_q    <= '0;
         fault_idx_q    <= '0;
         inject_count_q <= '0;
         valid_q        <= 1'b0;
         codeword_q     <= '0;
         fault_hit_q    <= 1'b0;
         busy_q         <= 1'b0;
      end else if (i_clk_en) begin
         state_q        <= state_d;
         lfsr_q         <= lfsr_d;
         thr_q          <= thr_d;
         mode_q         <= mode_d;
         dur_q          <= dur_d;
         rnd_en_q       <= rnd_en_d;
         fixed_idx_q    <= fixed_idx_d;
         mask_q         <= mask_d;
         remaining_q    <= remaining_d;
         fault_idx_q    <= fault_idx_d;
         inject_count_q <= inject_count_d;
         valid_q        <= valid_d;
         codeword_q     <= codeword_d;
         fault_hit_q    <= fault_hit_d;
         busy_q         <= busy_d;
      end
   end

   assign o_valid        = valid_q;
   assign o_codeword     = codeword_q;
   assign o_fault_hit    = fault_hit_q;
   assign o_fault_idx    = fault_idx_q;
   assign o_inject_count = inject_count_q;
   assign o_busy         = busy_q;

endmodule

// File: tb/tb_error_injector_multimode.sv
// -----------------------------------------------------------------------------
// tb_error_injector_multimode
//
// Self-checking bench for error_injector_multimode. A behavioural model
// (fault events described as "words left in the event", LFSR as tap-mask
// parity) predicts every registered output; scenario tasks compare the DUT
// against it and against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_error_injector_multimode;

   localparam int          CL    = 29;
   localparam int          IW    = 5;
   localparam logic [31:0] SEED  = 32'hACE10001;
   localparam logic [31:0] TAPS  = 32'h80200003;   // x^32, x^22, x^2, x^1

   logic          clk;
   logic          rst_n;
   logic          clk_en;
   logic          cfg_load;
   logic [31:0]   threshold;
   logic [1:0]    mode;
   logic [15:0]   duration;
   logic          rnd_en;
   logic [IW-1:0] fixed_idx;
   logic          arm;
   logic          clear;
   logic          valid;
   logic [CL-1:0] codeword;
   logic          o_valid;
   logic [CL-1:0] o_codeword;
   logic          o_fault_hit;
   logic [IW-1:0] o_fault_idx;
   logic [15:0]   o_inject_count;
   logic          o_busy;

   error_injector_multimode #(
      .CODEWORD_LENGTH (CL),
      .IDX_WIDTH       (IW),
      .LFSR_SEED       (SEED)
   ) dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_clk_en        (clk_en),
      .i_cfg_load      (cfg_load),
      .i_threshold     (threshold),
      .i_mode          (mode),
      .i_duration      (duration),
      .i_random_idx_en (rnd_en),
      .i_fixed_idx     (fixed_idx),
      .i_arm           (arm),
      .i_clear         (clear),
      .i_valid         (valid),
      .i_codeword      (codeword),
      .o_valid         (o_valid),
      .o_codeword      (o_codeword),
      .o_fault_hit     (o_fault_hit),
      .o_fault_idx     (o_fault_idx),
      .o_inject_count  (o_inject_count),
      .o_busy          (o_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t, limit 2000000", $time);
      $fatal(1, "watchdog expired");
   end

   int n_vec = 0;
   int n_bad = 0;

   wire [52:0] obs = {o_valid, o_codeword, o_fault_hit, o_fault_idx, o_inject_count, o_busy};

   // ---------------- behavioural reference model ----------------
   logic [31:0] m_lfsr;
   logic [31:0] m_thr;
   logic [1:0]  m_mode;
   int          m_dur;
   bit          m_rnd;
   int          m_fixed;
   bit          m_on;        // armed or in an event (not idle)
   int          m_left;      // words still to corrupt: 0 none, -1 forever
   logic [CL-1:0] m_mask;
   logic [IW-1:0] m_idx;
   int          m_count;
   bit          exp_valid;
   bit          exp_hit;
   logic [CL-1:0] exp_cw;

   function automatic logic [CL-1:0] apply_fault(input logic [CL-1:0] w, input logic [CL-1:0] m,
                                                 input logic [1:0] md);
      if (md == 2'd1)      return w & ~m;
      else if (md == 2'd2) return w | m;
      else if (md == 2'd3) return w ^ m;
      return w;
   endfunction

   function automatic logic [52:0] expected();
      return {exp_valid, exp_cw, exp_hit, m_idx, 16'(m_count), m_on};
   endfunction

   task automatic model_reset();
      m_lfsr = SEED; m_thr = '0; m_mode = '0; m_dur = 0; m_rnd = 0; m_fixed = 0;
      m_on = 0; m_left = 0; m_mask = '0; m_idx = '0; m_count = 0;
      exp_valid = 0; exp_hit = 0; exp_cw = '0;
   endtask

   task automatic model_eval();
      logic [CL-1:0] w;
      bit h;
      int idx;
      if (!clk_en) return;
      w = codeword;
      h = 0;
      if (clear) begin
         m_on = 0; m_left = 0; m_mask = '0;
      end else if (!m_on) begin
         if (cfg_load) begin
            m_thr = threshold; m_mode = mode; m_dur = int'(duration);
            m_rnd = rnd_en; m_fixed = int'(fixed_idx);
         end
         if (arm) m_on = 1;
      end else if (m_left != 0) begin
         if (valid) begin
            w = apply_fault(w, m_mask, m_mode); h = 1;
            if (m_left > 0) m_left--;
         end
      end else if (valid && m_mode != 2'd0 && m_lfsr < m_thr) begin
         idx = m_rnd ? int'(m_lfsr[15:0]) % CL : m_fixed;
         m_mask = '0;
         if (idx < CL) m_mask[idx] = 1'b1;
         m_idx = IW'(idx);
         if (m_count < 65535) m_count++;
         w = apply_fault(w, m_mask, m_mode); h = 1;
         m_left = (m_dur == 0) ? -1 : m_dur - 1;
      end
      exp_valid = valid;
      exp_cw    = w;
      exp_hit   = h;
      m_lfsr    = {m_lfsr[30:0], ^(m_lfsr & TAPS)};
   endtask

   // Apply current inputs for one clock and land #1 after the edge.
   task automatic cycle();
      model_eval();
      @(posedge clk);
      #1;
      n_vec++;
   endtask

   task automatic drive_idle();
      clk_en = 1; cfg_load = 0; arm = 0; clear = 0; valid = 0; codeword = '0;
   endtask

   task automatic setup(input logic [31:0] thr, input logic [1:0] md, input logic [15:0] dur,
                        input bit rnd, input int fix);
      drive_idle();
      clear = 1;
      cycle();
      clear = 0; cfg_load = 1;
      threshold = thr; mode = md; duration = dur; rnd_en = rnd; fixed_idx = IW'(fix);
      cycle();
      cfg_load = 0; arm = 1;
      cycle();
      arm = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      #12;
      n_vec++;
      if (obs !== 53'd0) begin
         $display("FAIL reset_outputs: got %h want 0", obs); n_bad++;
      end
      rst_n = 1;
      for (int k = 0; k < 20; k++) begin
         valid = 1; codeword = 29'h0AAAAAAA;
         cycle();
         if (obs !== expected()) begin
            $display("FAIL passthru_model k=%0d: got %h want %h", k, obs, expected()); n_bad++;
         end
         if (o_codeword !== 29'h0AAAAAAA || o_fault_hit !== 1'b0 || o_inject_count !== 16'd0) begin
            $display("FAIL passthru k=%0d: got cw=%h hit=%b cnt=%0d want cw=0aaaaaaa hit=0 cnt=0",
                     k, o_codeword, o_fault_hit, o_inject_count); n_bad++;
         end
      end
   endtask

   task automatic test_stuck_at_1();
      int c0;
      setup(32'hFFFFFFFF, 2'b10, 16'd1, 0, 3);
      c0 = m_count;
      for (int k = 1; k <= 10; k++) begin
         valid = 1; codeword = '0;
         cycle();
         if (obs !== expected()) begin
            $display("FAIL sa1_model k=%0d: got %h want %h", k, obs, expected()); n_bad++;
         end
         if (o_codeword !== 29'h8 || o_fault_hit !== 1'b1 || o_inject_count !== 16'(c0 + k)
             || o_fault_idx !== 5'd3 || o_busy !== 1'b1) begin
            $display("FAIL sa1 k=%0d: got cw=%h hit=%b cnt=%0d idx=%0d want cw=8 hit=1 cnt=%0d idx=3",
                     k, o_codeword, o_fault_hit, o_inject_count, o_fault_idx, c0 + k); n_bad++;
         end
      end
   endtask

   task automatic test_bit_flip_burst();
      int c0;
      setup(32'hFFFFFFFF, 2'b11, 16'd4, 0, 28);
      c0 = m_count;
      for (int k = 0; k < 12; k++) begin
         valid = 1; codeword = 29'h1FFFFFFF;
         cycle();
         if (obs !== expected()) begin
            $display("FAIL flip_model k=%0d: got %h want %h", k, obs, expected()); n_bad++;
         end
         if (o_codeword !== 29'h0FFFFFFF || o_inject_count !== 16'(c0 + k / 4 + 1)) begin
            $display("FAIL flip_burst k=%0d: got cw=%h cnt=%0d want cw=0fffffff cnt=%0d",
                     k, o_codeword, o_inject_count, c0 + k / 4 + 1); n_bad++;
         end
      end
   endtask

   task automatic test_permanent_stuck0_clear();
      int c0;
      setup(32'hFFFFFFFF, 2'b01, 16'd0, 0, 0);
      c0 = m_count;
      for (int k = 0; k < 15; k++) begin
         valid = (k % 5 != 4); codeword = 29'h1FFFFFFF;
         cycle();
         if (obs !== expected()) begin
            $display("FAIL perm_model k=%0d: got %h want %h", k, obs, expected()); n_bad++;
         end
         if (o_codeword !== (valid ? 29'h1FFFFFFE : 29'h1FFFFFFF) || o_fault_hit !== valid
             || o_inject_count !== 16'(c0 + 1)) begin
            $display("FAIL perm k=%0d: got cw=%h hit=%b cnt=%0d want hit=%b cnt=%0d",
                     k, o_codeword, o_fault_hit, o_inject_count, valid, c0 + 1); n_bad++;
         end
      end
      clear = 1; valid = 1;
      cycle();
      clear = 0;
      if (o_codeword !== 29'h1FFFFFFF || o_fault_hit !== 1'b0 || o_busy !== 1'b0) begin
         $display("FAIL perm_clear: got cw=%h hit=%b busy=%b want cw=1fffffff hit=0 busy=0",
                  o_codeword, o_fault_hit, o_busy); n_bad++;
      end
      cycle();
      if (obs !== expected() || o_codeword !== 29'h1FFFFFFF || o_inject_count !== 16'(c0 + 1)) begin
         $display("FAIL perm_after_clear: got %h want %h", obs, expected()); n_bad++;
      end
   endtask

   task automatic test_random_index();
      int hits;
      setup(32'h40000000, 2'b11, 16'd1, 1, 0);
      hits = 0;
      for (int k = 0; k < 10000; k++) begin
         valid = 1; codeword = CL'($urandom());
         cycle();
         if (obs !== expected()) begin
            $display("FAIL rnd_model k=%0d: got %h want %h", k, obs, expected()); n_bad++;
         end
         if (o_fault_hit) begin
            hits++;
            if (o_fault_idx >= IW'(CL)) begin
               $display("FAIL rnd_idx_range k=%0d: got idx=%0d want <29", k, o_fault_idx); n_bad++;
            end
         end
      end
      n_vec++;
      if (hits < 2300 || hits > 2700) begin
         $display("FAIL rnd_rate: got %0d hits of 10000 want 2300..2700", hits); n_bad++;
      end
   endtask

   task automatic test_edge_cases();
      int c0;
      // Threshold zero never fires; mode off never fires.
      for (int p = 0; p < 2; p++) begin
         if (p == 0) setup(32'h0, 2'b11, 16'd1, 1, 0);
         else        setup(32'hFFFFFFFF, 2'b00, 16'd1, 0, 2);
         c0 = m_count;
         for (int k = 0; k < 20; k++) begin
            valid = 1; codeword = CL'($urandom());
            cycle();
            if (obs !== expected() || o_fault_hit !== 1'b0 || o_codeword !== codeword
                || o_inject_count !== 16'(c0)) begin
               $display("FAIL nohit p=%0d k=%0d: got %h want %h", p, k, obs, expected()); n_bad++;
            end
         end
      end
      // Clear and arm together in IDLE: stays idle.
      drive_idle(); clear = 1;
      cycle();
      clear = 1; arm = 1;
      cycle();
      clear = 0; arm = 0;
      cycle();
      if (o_busy !== 1'b0 || obs !== expected()) begin
         $display("FAIL clear_arm: got busy=%b obs=%h want busy=0 obs=%h", o_busy, obs, expected());
         n_bad++;
      end
      // Clear on a trigger word: word clean, count unchanged.
      setup(32'hFFFFFFFF, 2'b10, 16'd1, 0, 3);
      c0 = m_count;
      clear = 1; valid = 1; codeword = '0;
      cycle();
      clear = 0;
      if (o_codeword !== 29'h0 || o_fault_hit !== 1'b0 || o_inject_count !== 16'(c0) || o_busy !== 1'b0) begin
         $display("FAIL clear_trigger: got cw=%h hit=%b cnt=%0d busy=%b want cw=0 hit=0 cnt=%0d busy=0",
                  o_codeword, o_fault_hit, o_inject_count, o_busy, c0); n_bad++;
      end
      // Out-of-range fixed index: trigger counted, word untouched.
      setup(32'hFFFFFFFF, 2'b11, 16'd1, 0, 30);
      c0 = m_count;
      valid = 1; codeword = 29'h12345678;
      cycle();
      if (obs !== expected() || o_codeword !== 29'h12345678 || o_inject_count !== 16'(c0 + 1)) begin
         $display("FAIL idx_oob: got cw=%h cnt=%0d want cw=12345678 cnt=%0d",
                  o_codeword, o_inject_count, c0 + 1); n_bad++;
      end
   endtask

   task automatic test_clk_en_freeze();
      int c0;
      setup(32'hFFFFFFFF, 2'b11, 16'd4, 0, 5);
      c0 = m_count;
      for (int k = 0; k < 2; k++) begin
         valid = 1; codeword = 29'h0;
         cycle();
      end
      for (int k = 0; k < 5; k++) begin
         clk_en = 0; valid = 1; codeword = CL'($urandom());
         cycle();
         if (obs !== expected() || o_codeword !== 29'h20) begin
            $display("FAIL freeze k=%0d: got %h want %h", k, obs, expected()); n_bad++;
         end
      end
      clk_en = 1;
      for (int k = 0; k < 3; k++) begin
         valid = 1; codeword = 29'h0;
         cycle();
         if (obs !== expected() || o_codeword !== 29'h20
             || o_inject_count !== 16'(k < 2 ? c0 + 1 : c0 + 2)) begin
            $display("FAIL resume k=%0d: got cw=%h cnt=%0d want cw=20 cnt=%0d",
                     k, o_codeword, o_inject_count, k < 2 ? c0 + 1 : c0 + 2); n_bad++;
         end
      end
   endtask

   task automatic test_async_reset();
      setup(32'hFFFFFFFF, 2'b11, 16'd0, 0, 7);
      for (int k = 0; k < 3; k++) begin
         valid = 1; codeword = 29'h0;
         cycle();
      end
      #2 rst_n = 0;
      #1;
      n_vec++;
      if (obs !== 53'd0) begin
         $display("FAIL async_reset: got %h want 0", obs); n_bad++;
      end
      model_reset();
      rst_n = 1;
      valid = 1; codeword = 29'h0ABCDEF0;
      cycle();
      if (obs !== expected() || o_codeword !== 29'h0ABCDEF0 || o_fault_hit !== 1'b0
          || o_inject_count !== 16'd0 || o_busy !== 1'b0) begin
         $display("FAIL post_reset: got %h want %h", obs, expected()); n_bad++;
      end
   endtask

   initial begin
      rst_n = 0;
      threshold = '0; mode = '0; duration = '0; rnd_en = 0; fixed_idx = '0;
      drive_idle();
      model_reset();
      test_reset();
      test_stuck_at_1();
      test_bit_flip_burst();
      test_permanent_stuck0_clear();
      test_random_index();
      test_edge_cases();
      test_clk_en_freeze();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/error_injector_multimode.md
# error_injector_multimode

Parametrised multi-mode fault injector for the ANcoded error-insertion bench. Sits between the encoder output and the decoder input, same slot as the stuck-at-1 inserter. Adds selectable stuck-at-0 / stuck-at-1 / bit-flip modes and a programmable fault duration (one word, N words, or permanent). Adds an arm/clear control FSM, a registered data path with valid, and an injection counter for coverage bookkeeping.

## Interface
- CODEWORD_LENGTH, 29, codeword width in bits (2..65535)
- IDX_WIDTH, 5, bit-index width; must satisfy 2^IDX_WIDTH >= CODEWORD_LENGTH
- LFSR_SEED, 32'hACE10001, internal LFSR reset value; must be nonzero
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_clk_en  in  1  global advance; low freezes all state, the LFSR and the outputs
- i_cfg_load  in  1  latch configuration inputs; honoured only in IDLE
- i_threshold  in  32  injection probability; fires when lfsr < threshold (unsigned)
- i_mode  in  2  00 off, 01 stuck-at-0, 10 stuck-at-1, 11 bit-flip
- i_duration  in  16  corrupted words per event; 0 = permanent until clear
- i_random_idx_en  in  1  1: random bit index; 0: use i_fixed_idx
- i_fixed_idx  in  IDX_WIDTH  fixed target bit
- i_arm  in  1  IDLE -> ARMED
- i_clear  in  1  abort any fault, return to IDLE
- i_valid  in  1  input word valid
- i_codeword  in  CODEWORD_LENGTH  original codeword
- o_valid  out  1  registered i_valid
- o_codeword  out  CODEWORD_LENGTH  possibly corrupted codeword
- o_fault_hit  out  1  this output word was corrupted
- o_fault_idx  out  IDX_WIDTH  bit index of the current or last fault
- o_inject_count  out  16  trigger events since reset; saturates at 16'hFFFF
- o_busy  out  1  state != IDLE

## Operation
- LFSR: 32-bit Fibonacci, x^32+x^22+x^2+x+1. Loads LFSR_SEED on reset. Advances on every i_clk_en cycle regardless of state.
- Config registers (thr, mode, dur, rnd_en, fixed_idx) reset to 0. Loaded on i_clk_en & i_cfg_load & IDLE. Ignored in all other states.
- FSM states:
  - IDLE: pass-through. i_arm goes to ARMED.
  - ARMED: on a word (i_clk_en & i_valid), trigger = (mode != 00) & (lfsr < thr).
    - Index = rnd_en ? (lfsr[15:0] % CODEWORD_LENGTH) : fixed_idx.
    - A fixed_idx >= CODEWORD_LENGTH gives an all-zero mask, but still counts as a trigger.
    - On trigger: latch the one-hot mask and index, increment o_inject_count, and corrupt this same word.
    - Next state: if dur == 1, stay ARMED. If dur == 0, go to ACTIVE permanently. Otherwise go to ACTIVE with remaining = dur-1.
  - ACTIVE: every valid word is corrupted with the latched mask; no re-trigger, no new index.
    - If dur != 0: decrement remaining per valid word; after the word with remaining == 1, go to ARMED.
- Corruption, by mode:
  - stuck-at-0: out = in & ~mask
  - stuck-at-1: out = in | mask
  - bit-flip: out = in ^ mask
- A stuck-at fault whose target bit already has the stuck value still asserts o_fault_hit.
- Priority within a cycle: i_clear > i_arm > trigger. i_clear in any state goes to IDLE, zeroes the mask and remaining; the count is kept. i_arm while ARMED or ACTIVE has no effect.
- o_inject_count clears only on i_rst_n.

## Timing
- Data latency: 1 cycle. o_valid, o_codeword and o_fault_hit update on i_clk_en edges from the same-cycle inputs. On cycles with i_valid low, o_codeword updates to the input and o_fault_hit = 0.
- The trigger compare uses the LFSR value present in the word's cycle (before that edge's advance).
- o_fault_idx updates one cycle after the trigger word, aligned with its o_valid.
- o_busy is registered; it rises the cycle after i_arm and falls the cycle after i_clear.
- i_clear in the same cycle as a trigger word: that word is not corrupted and the count does not increment.
- Reset values (asynchronous): o_valid 0, o_codeword 0, o_fault_hit 0, o_fault_idx 0, o_inject_count 0, o_busy 0, state IDLE, LFSR = LFSR_SEED.
- Deasserting i_rst_n mid-fault aborts the fault immediately; the first word after release is passed through.
- i_clk_en low: no state, counter, LFSR or output changes. Input words presented with i_clk_en low are dropped.

## Test plan
- Reset/pass-through: reset, stay IDLE, drive i_codeword = 29'h0AAAAAAA with valid for 20 cycles -> o_codeword identical, 1-cycle delayed, o_fault_hit 0, count 0.
- Always-fire stuck-at-1: load thr=32'hFFFFFFFF, mode 10, dur 1, fixed_idx 3, arm, input all-zero -> every output word = 29'h8, o_fault_hit 1, count increments per word.
- Bit-flip burst: thr=FFFFFFFF, mode 11, dur 4, fixed_idx 28, input 29'h1FFFFFFF -> 4 words of 29'h0FFFFFFF, then retrigger; count +1 per 4 words.
- Permanent stuck-at-0 and clear: dur 0, fixed_idx 0, input all-ones -> bit 0 low indefinitely, count stays 1. Pulse i_clear -> next word clean, o_busy 0 next cycle.
- Probabilistic random index: thr=32'h40000000, rnd_en 1, 10000 words -> hit rate 25% ±2%, all o_fault_idx < 29; reference LFSR model matches bit-exactly.
- Edge cases: thr=0 -> no hits. Mode 00 armed -> no hits. i_clear with i_arm in one cycle -> stays IDLE. i_clk_en low for 5 cycles mid-burst -> remaining count frozen. Async reset mid-burst -> all outputs 0 at once.
